// File: rtl/local_network_interface.sv
// rtl/local_network_interface.sv - PE-to-router local-port interface with injection and ejection queues
module local_network_interface #(
    parameter int                      coordWidth   = 3,
    parameter logic [2*coordWidth-1:0] routerID     = '0,
    parameter int                      dataWidth    = 32,
    parameter int                      addressWidth = 2,
    parameter int                      cntWidth     = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                peTxValid,
    output logic                                peTxReady,
    input  logic [2*coordWidth-1:0]             peTxDst,
    input  logic [dataWidth-4*coordWidth-1:0]   peTxPayload,
    output logic                                localReqUpStr,
    input  logic                                localGntUpStr,
    input  logic                                localUpStrFull,
    output logic [dataWidth-1:0]                localPacketIn,
    input  logic                                localReqDnStr,
    output logic                                localGntDnStr,
    output logic                                localDnStrFull,
    input  logic [dataWidth-1:0]                localPacketOut,
    output logic                                peRxValid,
    input  logic                                peRxReady,
    output logic [2*coordWidth-1:0]             peRxSrc,
    output logic [dataWidth-4*coordWidth-1:0]   peRxPayload,
    output logic [cntWidth-1:0]                 txCount,
    output logic [cntWidth-1:0]                 rxCount,
    output logic                                misrouteErr
);
    localparam int IDW   = 2 * coordWidth;
    localparam int PLW   = dataWidth - 2 * IDW;
    localparam int RXW   = dataWidth - IDW;
    localparam int DEPTH = 1 << addressWidth;
    localparam logic [addressWidth:0]   DEPTH_C  = (addressWidth + 1)'(DEPTH);
    localparam logic [addressWidth:0]   FILL_ONE = (addressWidth + 1)'(1);
    localparam logic [addressWidth-1:0] PTR_ONE  = addressWidth'(1);
    localparam logic [cntWidth-1:0]     CNT_ONE  = cntWidth'(1);

    typedef enum logic {S_IDLE, S_REQ} inj_state_e;

    // tx queue holds fully formed packets so the injection side only copies the head
    logic [dataWidth-1:0]    tx_mem_q [DEPTH];
    logic [dataWidth-1:0]    tx_mem_d [DEPTH];
    logic [addressWidth-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [addressWidth:0]   tx_fill_q, tx_fill_d;
    logic                    tx_full_q, tx_full_d;
    logic                    tx_empty, tx_push, tx_pop;
    logic [dataWidth-1:0]    tx_wdata, tx_head;

    // rx queue drops the destination field; only src and payload reach the PE
    logic [RXW-1:0]          rx_mem_q [DEPTH];
    logic [RXW-1:0]          rx_mem_d [DEPTH];
    logic [addressWidth-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [addressWidth:0]   rx_fill_q, rx_fill_d;
    logic                    rx_full_q, rx_full_d;
    logic                    rx_empty, rx_push, rx_pop, rx_room;
    logic [RXW-1:0]          rx_head;
    logic [IDW-1:0]          rx_dst;

    inj_state_e              state_q, state_d;
    logic                    pkt_load;
    logic [dataWidth-1:0]    pkt_q, pkt_d;
    logic [cntWidth-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic                    gnt_dn_q, gnt_dn_d;
    logic                    err_q, err_d;

    assign tx_wdata = {peTxDst, routerID, peTxPayload};
    assign tx_empty = (tx_fill_q == '0);
    assign tx_head  = tx_mem_q[tx_rd_q];
    assign tx_push  = peTxValid && !tx_full_q;

    assign rx_empty = (rx_fill_q == '0);
    assign rx_head  = rx_mem_q[rx_rd_q];
    assign rx_dst   = localPacketOut[dataWidth-1 -: IDW];

    // tx queue next state: write accepted PE message, advance head on router grant
    always_comb begin
        tx_mem_d  = tx_mem_q;
        tx_wr_d   = tx_wr_q;
        tx_rd_d   = tx_rd_q;
        tx_fill_d = tx_fill_q;
        if (tx_push) begin
            tx_mem_d[tx_wr_q] = tx_wdata;
            tx_wr_d           = tx_wr_q + PTR_ONE;
        end
        if (tx_pop) begin
            tx_rd_d = tx_rd_q + PTR_ONE;
        end
        if (tx_push && !tx_pop) begin
            tx_fill_d = tx_fill_q + FILL_ONE;
        end else if (!tx_push && tx_pop) begin
            tx_fill_d = tx_fill_q - FILL_ONE;
        end
        tx_full_d = (tx_fill_d == DEPTH_C);
    end

    // rx queue next state: capture granted router packet, advance head on PE accept
    always_comb begin
        rx_mem_d  = rx_mem_q;
        rx_wr_d   = rx_wr_q;
        rx_rd_d   = rx_rd_q;
        rx_fill_d = rx_fill_q;
        if (rx_push) begin
            rx_mem_d[rx_wr_q] = localPacketOut[RXW-1:0];
            rx_wr_d           = rx_wr_q + PTR_ONE;
        end
        if (rx_pop) begin
            rx_rd_d = rx_rd_q + PTR_ONE;
        end
        if (rx_push && !rx_pop) begin
            rx_fill_d = rx_fill_q + FILL_ONE;
        end else if (!rx_push && rx_pop) begin
            rx_fill_d = rx_fill_q - FILL_ONE;
        end
        rx_full_d = (rx_fill_d == DEPTH_C);
    end

    // queue storage is not reset; pointers and fill levels define what is valid
    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end

    // queue control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            tx_fill_q <= '0;
            tx_full_q <= 1'b0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            rx_fill_q <= '0;
            rx_full_q <= 1'b0;
        end else begin
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            tx_fill_q <= tx_fill_d;
            tx_full_q <= tx_full_d;
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
            rx_fill_q <= rx_fill_d;
            rx_full_q <= rx_full_d;
        end
    end

    // injection FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // injection FSM next state: request once a packet is queued and the router has room
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!tx_empty && !localUpStrFull) state_d = S_REQ;
            S_REQ:  if (localGntUpStr) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // injection FSM outputs: req held through router-full until granted
    always_comb begin
        localReqUpStr = (state_q == S_REQ);
        tx_pop        = (state_q == S_REQ) && localGntUpStr;
        pkt_load      = (state_q == S_IDLE) && !tx_empty && !localUpStrFull;
    end

    // ejection: grant is registered, never back-to-back, and only with guaranteed room
    always_comb begin
        rx_pop   = !rx_empty && peRxReady;
        rx_room  = !rx_full_q || rx_pop;
        gnt_dn_d = localReqDnStr && !gnt_dn_q && rx_room;
        rx_push  = localReqDnStr && gnt_dn_q;
        rx_cnt_d = rx_push ? rx_cnt_q + CNT_ONE : rx_cnt_q;
        err_d    = err_q || (rx_push && (rx_dst != routerID));
        pkt_d    = pkt_load ? tx_head : pkt_q;
        tx_cnt_d = tx_pop ? tx_cnt_q + CNT_ONE : tx_cnt_q;
    end

    // packet holding register, statistics and ejection handshake state
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_q    <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            gnt_dn_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pkt_q    <= pkt_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            gnt_dn_q <= gnt_dn_d;
            err_q    <= err_d;
        end
    end

    assign peTxReady      = !tx_full_q;
    assign localPacketIn  = pkt_q;
    assign localGntDnStr  = gnt_dn_q;
    assign localDnStrFull = rx_full_q;
    assign peRxValid      = !rx_empty;
    assign peRxSrc        = rx_head[RXW-1 -: IDW];
    assign peRxPayload    = rx_head[PLW-1:0];
    assign txCount        = tx_cnt_q;
    assign rxCount        = rx_cnt_q;
    assign misrouteErr    = err_q;

endmodule

// File: tb/tb_local_network_interface.sv
// tb/tb_local_network_interface.sv - randomized self-checking bench for local_network_interface
module tb_local_network_interface;
    localparam logic [5:0] MY_ID = 6'b000_000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, peTxValid, peTxReady, localReqUpStr, localGntUpStr, localUpStrFull;
    logic        localReqDnStr, localGntDnStr, localDnStrFull, peRxValid, peRxReady, misrouteErr;
    logic [5:0]  peTxDst, peRxSrc;
    logic [19:0] peTxPayload, peRxPayload;
    logic [31:0] localPacketIn, localPacketOut;
    logic [15:0] txCount, rxCount;

    local_network_interface #(.routerID(MY_ID)) dut (
        .clk(clk), .reset(reset),
        .peTxValid(peTxValid), .peTxReady(peTxReady), .peTxDst(peTxDst), .peTxPayload(peTxPayload),
        .localReqUpStr(localReqUpStr), .localGntUpStr(localGntUpStr), .localUpStrFull(localUpStrFull),
        .localPacketIn(localPacketIn),
        .localReqDnStr(localReqDnStr), .localGntDnStr(localGntDnStr), .localDnStrFull(localDnStrFull),
        .localPacketOut(localPacketOut),
        .peRxValid(peRxValid), .peRxReady(peRxReady), .peRxSrc(peRxSrc), .peRxPayload(peRxPayload),
        .txCount(txCount), .rxCount(rxCount), .misrouteErr(misrouteErr)
    );

    int tests  = 0;
    int failed = 0;

    // reference model: message queues plus the handshake rules at transaction level
    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    logic        req_m = 1'b0, gnt_m = 1'b0, err_m = 1'b0;
    logic [31:0] pkt_m = '0;
    logic [15:0] txc_m = '0, rxc_m = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        rst, tx_push, tx_pop, start_req, rx_pop, rx_cap, room, rreq;
        logic [31:0] new_pkt, cap_pkt;
        rst       = reset;
        tx_push   = peTxValid && (txq.size() < 4);
        tx_pop    = req_m && localGntUpStr;
        start_req = !req_m && (txq.size() > 0) && !localUpStrFull;
        new_pkt   = {peTxDst, MY_ID, peTxPayload};
        rx_pop    = (rxq.size() > 0) && peRxReady;
        rreq      = localReqDnStr;
        rx_cap    = rreq && gnt_m;
        room      = (rxq.size() < 4) || rx_pop;
        cap_pkt   = localPacketOut;
        @(posedge clk);
        if (rst) begin
            txq.delete();
            rxq.delete();
            req_m = 1'b0; gnt_m = 1'b0; err_m = 1'b0;
            pkt_m = '0; txc_m = '0; rxc_m = '0;
        end else begin
            if (start_req) pkt_m = txq[0];
            if (tx_pop) begin
                void'(txq.pop_front());
                txc_m++;
            end
            req_m = start_req || (req_m && !tx_pop);
            if (tx_push) txq.push_back(new_pkt);
            gnt_m = rreq && !gnt_m && room;
            if (rx_pop) void'(rxq.pop_front());
            if (rx_cap) begin
                rxq.push_back(cap_pkt);
                rxc_m++;
                if (cap_pkt[31:26] != MY_ID) err_m = 1'b1;
            end
        end
        #1;
        chk("req_up", localReqUpStr, req_m);
        chk("packet_in", localPacketIn, pkt_m);
        chk("tx_ready", peTxReady, txq.size() < 4);
        chk("gnt_dn", localGntDnStr, gnt_m);
        chk("dn_full", localDnStrFull, rxq.size() == 4);
        chk("rx_valid", peRxValid, rxq.size() > 0);
        if (rxq.size() > 0) begin
            chk("rx_src", peRxSrc, rxq[0][25:20]);
            chk("rx_payload", peRxPayload, rxq[0][19:0]);
        end
        chk("tx_count", txCount, txc_m);
        chk("rx_count", rxCount, rxc_m);
        chk("misroute", misrouteErr, err_m);
    endtask

    initial begin
        int grants;
        reset = 1'b1; peTxValid = 1'b0; peTxDst = '0; peTxPayload = '0;
        localGntUpStr = 1'b0; localUpStrFull = 1'b0; localReqDnStr = 1'b0;
        localPacketOut = '0; peRxReady = 1'b0;
        #1;
        step(); step();
        chk("rst_tx_ready", peTxReady, 1);
        chk("rst_req", localReqUpStr, 0);
        chk("rst_pkt", localPacketIn, 0);
        chk("rst_dn_full", localDnStrFull, 0);
        reset = 1'b0;

        // single message: packet format and request latency
        peTxValid = 1'b1; peTxDst = 6'b001_010; peTxPayload = 20'h12345;
        step();
        peTxValid = 1'b0;
        chk("t1_req_at_push", localReqUpStr, 0);
        step();
        chk("t1_req", localReqUpStr, 1);
        chk("t1_pkt", localPacketIn, 32'h2801_2345);
        localGntUpStr = 1'b1;
        step();
        localGntUpStr = 1'b0;
        chk("t1_req_low", localReqUpStr, 0);
        chk("t1_txcount", txCount, 1);

        // router full: queue fills, nothing requested, then drained in order
        reset = 1'b1; step(); reset = 1'b0;
        localUpStrFull = 1'b1;
        for (int i = 0; i < 4; i++) begin
            peTxValid = 1'b1; peTxDst = 6'($urandom); peTxPayload = 20'($urandom);
            step();
        end
        peTxValid = 1'b0;
        chk("t2_ready_full", peTxReady, 0);
        chk("t2_req_held", localReqUpStr, 0);
        peTxValid = 1'b1; peTxDst = 6'($urandom); peTxPayload = 20'($urandom);
        step();
        peTxValid = 1'b0;
        chk("t2_no_overflow", peTxReady, 0);
        localUpStrFull = 1'b0; localGntUpStr = 1'b1;
        repeat (10) step();
        localGntUpStr = 1'b0;
        chk("t2_txcount", txCount, 4);
        chk("t2_ready_drained", peTxReady, 1);

        // ejection back-pressure: four grants then stall until the PE pops
        reset = 1'b1; step(); reset = 1'b0;
        localReqDnStr = 1'b1; grants = 0;
        for (int i = 0; i < 10; i++) begin
            localPacketOut = {MY_ID, 6'h15, 20'($urandom)};
            step();
            if (localGntDnStr) grants++;
        end
        chk("t3_grants", grants, 4);
        chk("t3_dn_full", localDnStrFull, 1);
        chk("t3_rxcount", rxCount, 4);
        repeat (3) step();
        chk("t3_no_grant", localGntDnStr, 0);
        chk("t3_rxcount_held", rxCount, 4);
        peRxReady = 1'b1; step(); peRxReady = 1'b0;
        chk("t3_gnt_after_pop", localGntDnStr, 1);
        step();
        chk("t3_rxcount_5", rxCount, 5);

        // pop on a full queue with router request pending grants in the same decision
        peRxReady = 1'b1; step(); peRxReady = 1'b0;
        chk("t4_gnt", localGntDnStr, 1);
        step();
        chk("t4_full_again", localDnStrFull, 1);
        chk("t4_rxcount", rxCount, 6);
        localReqDnStr = 1'b0;

        // misrouted packet still delivered; flag cleared only by reset
        reset = 1'b1; step(); reset = 1'b0;
        localReqDnStr = 1'b1; localPacketOut = {6'b011_011, 6'h2a, 20'habcde};
        step(); step();
        localReqDnStr = 1'b0;
        chk("t5_err", misrouteErr, 1);
        chk("t5_valid", peRxValid, 1);
        chk("t5_src", peRxSrc, 6'h2a);
        chk("t5_payload", peRxPayload, 20'habcde);
        peRxReady = 1'b1; step(); peRxReady = 1'b0;
        chk("t5_err_sticky", misrouteErr, 1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t5_err_reset", misrouteErr, 0);

        // reset while requesting with three messages queued
        for (int i = 0; i < 3; i++) begin
            peTxValid = 1'b1; peTxDst = 6'($urandom); peTxPayload = 20'($urandom);
            step();
        end
        peTxValid = 1'b0;
        chk("t6_req", localReqUpStr, 1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t6_req_cleared", localReqUpStr, 0);
        chk("t6_ready", peTxReady, 1);
        chk("t6_txcount", txCount, 0);
        repeat (3) step();
        chk("t6_still_idle", localReqUpStr, 0);

        // randomized traffic on both directions
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 63) == 0);
            peTxValid      = 1'($urandom_range(0, 1));
            peTxDst        = 6'($urandom);
            peTxPayload    = 20'($urandom);
            localUpStrFull = ($urandom_range(0, 3) == 0);
            localGntUpStr  = 1'($urandom_range(0, 1));
            localReqDnStr  = 1'($urandom_range(0, 1));
            localPacketOut = {(($urandom_range(0, 3) == 0) ? 6'($urandom) : MY_ID), 26'($urandom)};
            peRxReady      = 1'($urandom_range(0, 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
